// File: rtl/oqpsk_spreader.sv
// IEEE 802.15.4 2.4 GHz DSSS spreader: turns the framed bit stream into one
// registered 32-chip word per 4-bit symbol, LSB-first within each byte.
module oqpsk_spreader #(
   parameter logic [31:0] SYMBOL0  = 32'hD9C3522E,
   parameter logic [31:0] ODD_MASK = 32'h55555555
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  din,
   input  logic        indicator,
   output logic [31:0] chips,
   output logic        chip_valid,
   output logic        frame_start,
   output logic        frame_end,
   output logic        sync_err
);

   typedef enum logic {StIdle, StActive} state_e;

   state_e      state_q, state_d;
   logic [2:0]  phase_q, phase_d;
   logic [2:0]  nib_q, nib_d;
   logic        first_q, first_d;
   logic [31:0] chips_q, chips_d;
   logic        chip_valid_q, chip_valid_d;
   logic        frame_start_q, frame_start_d;
   logic        frame_end_q, frame_end_d;
   logic        sync_err_q, sync_err_d;

   logic        cur_bit;
   logic        complete;
   logic [3:0]  symbol;

   // Symbols 0-7 are cyclic shifts of SYMBOL0; 8-15 additionally flip odd chips.
   function automatic logic [31:0] chip_map(input logic [3:0] sym);
      logic [63:0] dbl;
      logic [31:0] rot;
      dbl = {SYMBOL0, SYMBOL0} >> {sym[2:0], 2'b00};
      rot = dbl[31:0];
      return sym[3] ? (rot ^ ODD_MASK) : rot;
   endfunction

   assign cur_bit  = din[phase_q];
   assign complete = (phase_q[1:0] == 2'b11);
   assign symbol   = {cur_bit, nib_q};

   always_comb begin
      state_d       = state_q;
      phase_d       = phase_q;
      nib_d         = nib_q;
      first_d       = first_q;
      chips_d       = chips_q;
      chip_valid_d  = 1'b0;
      frame_start_d = 1'b0;
      frame_end_d   = 1'b0;
      sync_err_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (indicator) begin
               state_d = StActive;
               phase_d = 3'd0;
               first_d = 1'b1;
            end
         end
         StActive: begin
            case (phase_q[1:0])
               2'd0:    nib_d[0] = cur_bit;
               2'd1:    nib_d[1] = cur_bit;
               2'd2:    nib_d[2] = cur_bit;
               default: ;
            endcase
            if (complete) begin
               chips_d       = chip_map(symbol);
               chip_valid_d  = 1'b1;
               frame_start_d = first_q;
               first_d       = 1'b0;
            end
            phase_d = phase_q + 3'd1;
            // End of frame: a partial nibble is dropped and flagged as a sync error.
            if (indicator) begin
               state_d     = StIdle;
               phase_d     = 3'd0;
               frame_end_d = 1'b1;
               sync_err_d  = (phase_q != 3'd7);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StIdle;
         phase_q       <= 3'd0;
         nib_q         <= 3'd0;
         first_q       <= 1'b1;
         chips_q       <= 32'd0;
         chip_valid_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_end_q   <= 1'b0;
         sync_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         nib_q         <= nib_d;
         first_q       <= first_d;
         chips_q       <= chips_d;
         chip_valid_q  <= chip_valid_d;
         frame_start_q <= frame_start_d;
         frame_end_q   <= frame_end_d;
         sync_err_q    <= sync_err_d;
      end
   end

   assign chips       = chips_q;
   assign chip_valid  = chip_valid_q;
   assign frame_start = frame_start_q;
   assign frame_end   = frame_end_q;
   assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_oqpsk_spreader.sv
// Directed self-checking bench for oqpsk_spreader; expected chip words are
// hand-computed from SYMBOL0 rotations and the odd-chip mask.
module tb_oqpsk_spreader;

   logic        clk;
   logic        reset_n;
   logic [7:0]  din;
   logic        indicator;
   logic [31:0] chips;
   logic        chip_valid;
   logic        frame_start;
   logic        frame_end;
   logic        sync_err;

   int checks = 0;
   int errors = 0;

   oqpsk_spreader dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .din        (din),
      .indicator  (indicator),
      .chips      (chips),
      .chip_valid (chip_valid),
      .frame_start(frame_start),
      .frame_end  (frame_end),
      .sync_err   (sync_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply inputs for one cycle; afterwards the outputs belong to the next cycle.
   task automatic cyc(input logic [7:0] d, input logic ind);
      din       = d;
      indicator = ind;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      din       = 8'h00;
      indicator = 1'b0;
      #3;
      checks++;
      if ({chips, chip_valid, frame_start, frame_end, sync_err} !== 36'd0) begin
         errors++;
         $display("FAIL reset_outputs: got chips=%h v=%b s=%b e=%b x=%b want all 0",
                  chips, chip_valid, frame_start, frame_end, sync_err);
      end
      #9 reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_idle();
      for (int i = 0; i < 20; i++) begin
         cyc(8'hFF, 1'b0);
         checks++;
         if (chip_valid !== 1'b0 || chips !== 32'd0) begin
            errors++;
            $display("FAIL idle_%0d: got v=%b chips=%h want v=0 chips=00000000",
                     i, chip_valid, chips);
         end
      end
   endtask

   task automatic test_single_byte();
      cyc(8'h00, 1'b1);
      for (int i = 0; i < 8; i++) begin
         cyc(8'h00, i == 7);
         if (i == 3) begin
            checks++;
            if (chip_valid !== 1'b1 || chips !== 32'hD9C3522E || frame_start !== 1'b1 ||
                frame_end !== 1'b0) begin
               errors++;
               $display("FAIL single_low: got v=%b chips=%h s=%b e=%b want 1 d9c3522e 1 0",
                        chip_valid, chips, frame_start, frame_end);
            end
         end else if (i == 7) begin
            checks++;
            if (chip_valid !== 1'b1 || chips !== 32'hD9C3522E || frame_start !== 1'b0 ||
                frame_end !== 1'b1 || sync_err !== 1'b0) begin
               errors++;
               $display("FAIL single_high: got v=%b chips=%h s=%b e=%b x=%b want 1 d9c3522e 0 1 0",
                        chip_valid, chips, frame_start, frame_end, sync_err);
            end
         end else begin
            checks++;
            if (chip_valid !== 1'b0) begin
               errors++;
               $display("FAIL single_gap_%0d: got v=%b want 0", i, chip_valid);
            end
         end
      end
      cyc(8'h00, 1'b0);
      checks++;
      if (chip_valid !== 1'b0 || frame_end !== 1'b0) begin
         errors++;
         $display("FAIL single_after: got v=%b e=%b want 0 0", chip_valid, frame_end);
      end
   endtask

   task automatic test_two_bytes();
      logic [7:0]  bytes [2];
      logic [31:0] exp_w [4];
      bytes[0] = 8'hA7;
      bytes[1] = 8'hAA;
      exp_w[0] = 32'h9C3522ED;
      exp_w[1] = 32'h7B8C9607;
      exp_w[2] = 32'h7B8C9607;
      exp_w[3] = 32'h7B8C9607;
      cyc(8'h00, 1'b1);
      for (int i = 0; i < 16; i++) begin
         cyc(bytes[i / 8], i == 15);
         if ((i % 4) == 3) begin
            checks++;
            if (chip_valid !== 1'b1 || chips !== exp_w[i / 4] ||
                frame_start !== (i == 3) || frame_end !== (i == 15)) begin
               errors++;
               $display("FAIL two_bytes_w%0d: got v=%b chips=%h s=%b e=%b want 1 %h %b %b",
                        i / 4, chip_valid, chips, frame_start, frame_end, exp_w[i / 4],
                        i == 3, i == 15);
            end
         end
      end
   endtask

   task automatic test_abort_phase5();
      cyc(8'h00, 1'b1);
      for (int i = 0; i < 6; i++) begin
         cyc(8'h3C, i == 5);
         if (i == 3) begin
            checks++;
            if (chip_valid !== 1'b1 || chips !== 32'h077B8C96 || frame_start !== 1'b1) begin
               errors++;
               $display("FAIL abort_low: got v=%b chips=%h s=%b want 1 077b8c96 1",
                        chip_valid, chips, frame_start);
            end
         end
      end
      checks++;
      if (frame_end !== 1'b1 || sync_err !== 1'b1 || chip_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_end: got e=%b x=%b v=%b want 1 1 0",
                  frame_end, sync_err, chip_valid);
      end
      for (int i = 0; i < 6; i++) cyc(8'hFF, 1'b0);
      checks++;
      if (chip_valid !== 1'b0 || sync_err !== 1'b0 || chips !== 32'h077B8C96) begin
         errors++;
         $display("FAIL abort_idle: got v=%b x=%b chips=%h want 0 0 077b8c96",
                  chip_valid, sync_err, chips);
      end
   endtask

   task automatic test_back_to_back();
      cyc(8'h00, 1'b1);
      for (int i = 0; i < 8; i++) cyc(8'h00, i == 7);
      checks++;
      if (frame_end !== 1'b1 || chip_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_end1: got e=%b v=%b want 1 1", frame_end, chip_valid);
      end
      // New frame announced while the previous frame's final word is on the outputs.
      cyc(8'h00, 1'b1);
      for (int i = 0; i < 8; i++) begin
         cyc(8'h5F, i == 7);
         if (i == 3) begin
            checks++;
            if (chip_valid !== 1'b1 || frame_start !== 1'b1 || chips !== 32'hC96077B8) begin
               errors++;
               $display("FAIL b2b_start2: got v=%b s=%b chips=%h want 1 1 c96077b8",
                        chip_valid, frame_start, chips);
            end
         end
      end
      checks++;
      if (chip_valid !== 1'b1 || frame_end !== 1'b1 || chips !== 32'h3522ED9C) begin
         errors++;
         $display("FAIL b2b_end2: got v=%b e=%b chips=%h want 1 1 3522ed9c",
                  chip_valid, frame_end, chips);
      end
   endtask

   task automatic test_reset_mid();
      cyc(8'h00, 1'b1);
      for (int i = 0; i < 8; i++) cyc(8'h00, 1'b0);
      cyc(8'h00, 1'b0);
      cyc(8'h00, 1'b0);
      checks++;
      if (chips !== 32'hD9C3522E) begin
         errors++;
         $display("FAIL mid_pre: got chips=%h want d9c3522e", chips);
      end
      din = 8'hFF;
      #1 reset_n = 1'b0;
      #1;
      checks++;
      if ({chips, chip_valid, frame_start, frame_end, sync_err} !== 36'd0) begin
         errors++;
         $display("FAIL mid_async: got chips=%h v=%b s=%b e=%b x=%b want all 0",
                  chips, chip_valid, frame_start, frame_end, sync_err);
      end
      #10 reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc(8'hFF, 1'b0);
         checks++;
         if (chip_valid !== 1'b0 || frame_end !== 1'b0) begin
            errors++;
            $display("FAIL mid_after_%0d: got v=%b e=%b want 0 0", i, chip_valid, frame_end);
         end
      end
   endtask

   task automatic test_short_frame();
      cyc(8'h00, 1'b1);
      cyc(8'hFF, 1'b0);
      cyc(8'hFF, 1'b1);
      checks++;
      if (frame_end !== 1'b1 || sync_err !== 1'b1 || frame_start !== 1'b0 ||
          chip_valid !== 1'b0) begin
         errors++;
         $display("FAIL short_frame: got e=%b x=%b s=%b v=%b want 1 1 0 0",
                  frame_end, sync_err, frame_start, chip_valid);
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_single_byte();
      test_two_bytes();
      test_abort_phase5();
      test_back_to_back();
      test_reset_mid();
      test_short_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
